// File: rtl/piezo_sequencer_pkg.sv
// Shared types and timing defaults for the piezo audio path (chime FSM, top, LCD).
// Defaults assume the 1 kHz system tick, so every *_MS value is also a cycle count.
package piezo_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } chime_state_t;

  localparam int CHIME_ON_MS_DEF     = 200;
  localparam int CHIME_PERIOD_MS_DEF = 500;
  localparam int TRILL_MS_DEF        = 50;
  localparam int BEEP_PERIOD_MS_DEF  = 1000;
  localparam int BEEP_ON_MS_DEF      = 500;

  // 24-hour KST to 12-hour strike count; midnight and noon both strike 12.
  function automatic logic [3:0] chime_target(input logic [4:0] hour);
    if (hour == 5'd0)
      return 4'd12;
    else if (hour <= 5'd12)
      return hour[3:0];
    else
      return 4'(hour - 5'd12);
  endfunction

endpackage

// File: rtl/piezo_sequencer_chime_fsm.sv
// Hourly chime: top-of-hour trigger detection, strike-count latch and stroke timing.
// Optional macro PIEZO_QUIET_HOURS_EN suppresses triggers from 22:00 through 06:59.
//
// state | meaning
// IDLE  | no chime running; chime_strokes holds the last completed count
// ON    | stroke audible, st counts 0..CHIME_ON_MS-1
// OFF   | gap after stroke, st counts CHIME_ON_MS..CHIME_PERIOD_MS-1
module piezo_sequencer_chime_fsm
  import piezo_sequencer_pkg::*;
#(
  parameter int CHIME_ON_MS     = CHIME_ON_MS_DEF,
  parameter int CHIME_PERIOD_MS = CHIME_PERIOD_MS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hour_kst,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       chime_on,
  output logic       chime_active,
  output logic [3:0] chime_strokes
);

  localparam int ST_W = (CHIME_PERIOD_MS > 1) ? $clog2(CHIME_PERIOD_MS) : 1;

  chime_state_t    state, state_nxt;
  logic [ST_W-1:0] st, st_nxt;
  logic [3:0]      strokes_nxt;
  logic [3:0]      target, target_nxt;
  logic [5:0]      sec_prev;
  logic            quiet;
  logic            trigger;

`ifdef PIEZO_QUIET_HOURS_EN
  assign quiet = (hour_kst >= 5'd22) || (hour_kst <= 5'd6);
`else
  assign quiet = 1'b0;
`endif

  // sec_prev resets to 0, so a post-reset cur_sec of 0 is not a tick
  assign trigger = (cur_sec != sec_prev) && (cur_min == 6'd0) && (cur_sec == 6'd0) && !quiet;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      st            <= '0;
      chime_strokes <= 4'd0;
      target        <= 4'd0;
      sec_prev      <= 6'd0;
    end else begin
      state         <= state_nxt;
      st            <= st_nxt;
      chime_strokes <= strokes_nxt;
      target        <= target_nxt;
      sec_prev      <= cur_sec;
    end
  end

  always_comb begin
    state_nxt   = state;
    st_nxt      = st;
    strokes_nxt = chime_strokes;
    target_nxt  = target;
    if (trigger) begin
      state_nxt   = ON;
      st_nxt      = '0;
      strokes_nxt = 4'd0;
      target_nxt  = chime_target(hour_kst);
    end else begin
      case (state)
        ON: begin
          st_nxt = st + 1'b1;
          if (st == ST_W'(CHIME_ON_MS - 1))
            state_nxt = OFF;
        end
        OFF: begin
          if (st == ST_W'(CHIME_PERIOD_MS - 1)) begin
            strokes_nxt = chime_strokes + 4'd1;
            st_nxt      = '0;
            state_nxt   = ((chime_strokes + 4'd1) == target) ? IDLE : ON;
          end else begin
            st_nxt = st + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign chime_on     = (state == ON);
  assign chime_active = (state != IDLE);

endmodule

// File: rtl/piezo_sequencer.sv
// Piezo driver: alarm trill, timer beep and hourly chime muxed by priority onto one pin.
// Optional macro PIEZO_QUIET_HOURS_EN (inside the chime FSM) mutes night-time chimes.
module piezo_sequencer
  import piezo_sequencer_pkg::*;
#(
  parameter int CHIME_ON_MS     = CHIME_ON_MS_DEF,
  parameter int CHIME_PERIOD_MS = CHIME_PERIOD_MS_DEF,
  parameter int TRILL_MS        = TRILL_MS_DEF,
  parameter int BEEP_PERIOD_MS  = BEEP_PERIOD_MS_DEF,
  parameter int BEEP_ON_MS      = BEEP_ON_MS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_ringing,
  input  logic       tm_alarm,
  input  logic [4:0] hour_kst,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       piezo,
  output logic       chime_active,
  output logic [3:0] chime_strokes
);

  localparam int TR_W = (TRILL_MS > 1) ? $clog2(TRILL_MS) : 1;
  localparam int BP_W = (BEEP_PERIOD_MS > 1) ? $clog2(BEEP_PERIOD_MS) : 1;

  logic [TR_W-1:0] trill_cnt;
  logic [BP_W-1:0] beep_cnt;
  logic            tone_sel;
  logic            half;
  logic            chime_on;
  logic            piezo_nxt;

  piezo_sequencer_chime_fsm #(
    .CHIME_ON_MS     (CHIME_ON_MS),
    .CHIME_PERIOD_MS (CHIME_PERIOD_MS)
  ) u_chime (
    .clk           (clk),
    .rst           (rst),
    .hour_kst      (hour_kst),
    .cur_min       (cur_min),
    .cur_sec       (cur_sec),
    .chime_on      (chime_on),
    .chime_active  (chime_active),
    .chime_strokes (chime_strokes)
  );

  // Pattern counters free-run so a source switch picks up the current phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      trill_cnt <= '0;
      tone_sel  <= 1'b0;
      half      <= 1'b0;
      beep_cnt  <= '0;
      piezo     <= 1'b0;
    end else begin
      if (trill_cnt == TR_W'(TRILL_MS - 1)) begin
        trill_cnt <= '0;
        tone_sel  <= ~tone_sel;
      end else begin
        trill_cnt <= trill_cnt + 1'b1;
      end
      half     <= ~half;
      beep_cnt <= (beep_cnt == BP_W'(BEEP_PERIOD_MS - 1)) ? '0 : beep_cnt + 1'b1;
      piezo    <= piezo_nxt;
    end
  end

  always_comb begin
    piezo_nxt = 1'b0;
    if (alarm_ringing)
      piezo_nxt = (!tone_sel || half) ? ~piezo : piezo;
    else if (tm_alarm)
      piezo_nxt = (beep_cnt < BP_W'(BEEP_ON_MS)) ? ~piezo : 1'b0;
    else if (chime_on)
      piezo_nxt = ~piezo;
  end

endmodule

// File: tb/tb_piezo_sequencer.sv
// Self-checking bench for piezo_sequencer: per-cycle reference model, strike table, random mix.
module tb_piezo_sequencer;

  localparam int C_ON  = 200;
  localparam int C_PER = 500;
  localparam int TRILL = 50;
  localparam int B_PER = 1000;
  localparam int B_ON  = 500;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alarm_ringing = 1'b0;
  logic       tm_alarm = 1'b0;
  logic [4:0] hour_kst = 5'd0;
  logic [5:0] cur_min = 6'd0;
  logic [5:0] cur_sec = 6'd0;
  logic       piezo;
  logic       chime_active;
  logic [3:0] chime_strokes;

  int total = 0;
  int bad = 0;

  // reference model: cycle count since reset plus trigger cycle and strike count
  int         m_n = 0;
  int         m_trig = -1;
  int         m_tgt = 0;
  bit         m_piezo = 1'b0;
  logic [5:0] m_secp = 6'd0;

  typedef struct {
    int hour;
    int strokes;
  } vec_t;
  vec_t tbl[7];

  piezo_sequencer #(
    .CHIME_ON_MS     (C_ON),
    .CHIME_PERIOD_MS (C_PER),
    .TRILL_MS        (TRILL),
    .BEEP_PERIOD_MS  (B_PER),
    .BEEP_ON_MS      (B_ON)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alarm_ringing (alarm_ringing),
    .tm_alarm      (tm_alarm),
    .hour_kst      (hour_kst),
    .cur_min       (cur_min),
    .cur_sec       (cur_sec),
    .piezo         (piezo),
    .chime_active  (chime_active),
    .chime_strokes (chime_strokes)
  );

  always #5 clk = ~clk;

  function automatic bit m_quiet(input int h);
`ifdef PIEZO_QUIET_HOURS_EN
    return (h >= 22) || (h <= 6);
`else
    return (h < 0);
`endif
  endfunction

  function automatic int m_pos(input int n);
    return (m_trig < 0) ? -1 : n - m_trig - 1;
  endfunction

  function automatic bit m_on(input int n);
    int p;
    p = m_pos(n);
    return (p >= 0) && (p < C_PER * m_tgt) && ((p % C_PER) < C_ON);
  endfunction

  function automatic bit m_act(input int n);
    int p;
    p = m_pos(n);
    return (p >= 0) && (p < C_PER * m_tgt);
  endfunction

  function automatic int m_strk(input int n);
    int p;
    p = m_pos(n);
    if (p < 0) return 0;
    return (p / C_PER < m_tgt) ? p / C_PER : m_tgt;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // one clock: advance the model with the current inputs, then compare after the edge
  task automatic cyc();
    bit tsel;
    bit hf;
    bit trig;
    int got;
    int exp;
    if (rst) begin
      m_n = 0;
      m_trig = -1;
      m_tgt = 0;
      m_piezo = 1'b0;
      m_secp = 6'd0;
    end else begin
      tsel = ((m_n / TRILL) % 2) == 1;
      hf   = (m_n % 2) == 1;
      if (alarm_ringing)
        m_piezo = (!tsel || hf) ? !m_piezo : m_piezo;
      else if (tm_alarm)
        m_piezo = ((m_n % B_PER) < B_ON) ? !m_piezo : 1'b0;
      else if (m_on(m_n))
        m_piezo = !m_piezo;
      else
        m_piezo = 1'b0;
      trig = (cur_sec != m_secp) && (cur_min == 6'd0) && (cur_sec == 6'd0)
             && !m_quiet(int'(hour_kst));
      m_secp = cur_sec;
      if (trig) begin
        m_trig = m_n;
        m_tgt  = ((int'(hour_kst) + 11) % 12) + 1;
      end
      m_n++;
    end
    @(posedge clk);
    #1;
    got = {26'd0, piezo, chime_active, chime_strokes};
    exp = (int'(m_piezo) * 32) + (int'(m_act(m_n)) * 16) + m_strk(m_n);
    check("outputs{piezo,active,strokes}", got, exp);
  endtask

  task automatic run(input int k);
    repeat (k) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic fire_chime(input int h);
    hour_kst = 5'(h);
    cur_min  = 6'd0;
    cur_sec  = 6'd59;
    cyc();
    cur_sec = 6'd0;
    cyc();
  endtask

  initial begin
    int  tog;
    int  act_cnt;
    bit  prev;
    bit  seen;
    int  len;

`ifdef PIEZO_QUIET_HOURS_EN
    tbl[0] = '{23, 0};
    tbl[1] = '{6, 0};
    tbl[2] = '{7, 7};
    tbl[3] = '{15, 3};
    tbl[4] = '{12, 12};
    tbl[5] = '{13, 1};
    tbl[6] = '{0, 0};
`else
    tbl[0] = '{15, 3};
    tbl[1] = '{0, 12};
    tbl[2] = '{12, 12};
    tbl[3] = '{1, 1};
    tbl[4] = '{13, 1};
    tbl[5] = '{23, 11};
    tbl[6] = '{7, 7};
`endif

    // reset, then 00:00 on the clock with no second edge: must stay silent
    do_reset();
    check("reset_piezo", piezo, 0);
    check("reset_active", chime_active, 0);
    check("reset_strokes", chime_strokes, 0);
    tog = 0;
    for (int i = 0; i < 2000; i++) begin
      prev = piezo;
      cyc();
      if (piezo != prev) tog++;
    end
    check("no_chime_toggles", tog, 0);
    check("no_chime_active", chime_active, 0);

    // strike-count table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      fire_chime(tbl[i].hour);
      act_cnt = chime_active ? 1 : 0;
      seen = chime_active;
      len = (tbl[i].strokes == 0) ? 20 : C_PER * tbl[i].strokes + 10;
      for (int c = 0; c < len; c++) begin
        cyc();
        if (chime_active) begin
          act_cnt++;
          seen = 1'b1;
        end
      end
      check("tbl_strokes", chime_strokes, tbl[i].strokes);
      check("tbl_active_seen", seen, (tbl[i].strokes != 0) ? 1 : 0);
      check("tbl_active_len", act_cnt, C_PER * tbl[i].strokes);
      check("tbl_idle_after", chime_active, 0);
    end

    // alarm trill: 50 full-rate toggles then 25 half-rate, drop -> silent next edge
    do_reset();
    alarm_ringing = 1'b1;
    tog = 0;
    for (int i = 0; i < 50; i++) begin
      prev = piezo;
      cyc();
      if (piezo != prev) tog++;
    end
    check("trill_fast_toggles", tog, 50);
    tog = 0;
    for (int i = 0; i < 50; i++) begin
      prev = piezo;
      cyc();
      if (piezo != prev) tog++;
    end
    check("trill_slow_toggles", tog, 25);
    run(100);
    alarm_ringing = 1'b0;
    cyc();
    check("alarm_drop_piezo", piezo, 0);

    // timer masks a running chime, which still finishes on time
    do_reset();
    fire_chime(15);
    tm_alarm = 1'b1;
    run(C_PER * 3 - 1);
    check("masked_chime_active", chime_active, 1);
    check("masked_chime_strokes_pre", chime_strokes, 2);
    cyc();
    check("masked_chime_done", chime_active, 0);
    check("masked_chime_strokes", chime_strokes, 3);
    tm_alarm = 1'b0;

    // retrigger mid-chime restarts with the new count
    do_reset();
    fire_chime(17);
    run(700);
    check("retrig_mid_strokes", chime_strokes, 1);
    fire_chime(14);
    check("retrig_restart_strokes", chime_strokes, 0);
    run(C_PER * 2 + 10);
    check("retrig_final_strokes", chime_strokes, 2);

    // reset mid-chime
    fire_chime(15);
    run(100);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midreset_piezo", piezo, 0);
    check("midreset_active", chime_active, 0);
    check("midreset_strokes", chime_strokes, 0);

    // random mix of sources, clock values and chime triggers
    do_reset();
    for (int seg = 0; seg < 60; seg++) begin
      alarm_ringing = ($urandom_range(0, 3) == 0);
      tm_alarm      = ($urandom_range(0, 2) == 0);
      hour_kst      = 5'($urandom_range(0, 23));
      if ($urandom_range(0, 4) == 0) fire_chime(int'(hour_kst));
      cur_min = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(1, 59));
      cur_sec = 6'($urandom_range(0, 59));
      run($urandom_range(1, 400));
    end
    alarm_ringing = 1'b0;
    tm_alarm = 1'b0;
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piezo_sequencer.md
Name: piezo_sequencer

Overview:
- Downstream audio stage of the world clock: consumes the alarm-ringing and timer-expired flags plus the KST time-of-day, and drives the single piezo pin.
- Generates three distinct patterns: a two-tone trill for the alarm clock, a 0.5 s on/off beep for the timer, and an hourly chime that strikes once per hour on a 12-hour count.
- Runs on the design's 1 kHz system tick (1 cycle = 1 ms).
- Replaces the inline piezo logic of the top level.

Parameters:
- CHIME_ON_MS, 200, cycles the piezo sounds per chime stroke.
- CHIME_PERIOD_MS, 500, cycles per stroke (on + off); must be > CHIME_ON_MS.
- TRILL_MS, 50, cycles per tone half of the alarm trill.
- BEEP_PERIOD_MS, 1000, timer beep period in cycles.
- BEEP_ON_MS, 500, audible cycles per beep period; must be < BEEP_PERIOD_MS.

Ports:
- clk  in  1  1 kHz system clock.
- rst  in  1  synchronous active-high reset.
- alarm_ringing  in  1  alarm clock is ringing (highest priority).
- tm_alarm  in  1  timer expired.
- hour_kst  in  5  KST hour, 0..23.
- cur_min  in  6  minute, 0..59.
- cur_sec  in  6  second, 0..59.
- piezo  out  1  piezo drive, registered.
- chime_active  out  1  chime sequencer is not IDLE.
- chime_strokes  out  4  strokes completed in the current chime, 0..12.

Behaviour:
- One clock is used; reset is synchronous and active-high. All registers clear on the clk edge where rst=1.
- Reset values: piezo=0, chime_active=0, chime_strokes=0, sec_prev=0, and all counters 0.
- sec_tick = (cur_sec != sec_prev). sec_prev <= cur_sec every cycle. Because sec_prev resets to 0, a post-reset cur_sec=0 produces no tick.

Chime trigger:
- Condition: sec_tick && cur_min==0 && cur_sec==0.
- target = 12 if hour_kst==0; hour_kst if 1..12; hour_kst-12 if 13..23. target is latched at trigger. hour_kst values above 23 are treated as (hour_kst-12) truncated to 4 bits; this is undefined use.

Chime FSM (states IDLE, ON, OFF; stroke timer st counts 0..CHIME_PERIOD_MS-1):
- IDLE -> ON on trigger: st=0, chime_strokes=0.
- ON: st increments each cycle. When st reaches CHIME_ON_MS-1, go to OFF.
- OFF: at st==CHIME_PERIOD_MS-1, chime_strokes increments.
  - If chime_strokes+1 == target: go to IDLE.
  - Otherwise: st=0 and go to ON.
- A trigger in any state restarts the sequence from ON with the new target.
- chime_strokes holds its final value in IDLE until the next trigger or reset.
- The FSM runs even while masked by a higher-priority source; strokes are not deferred.

Free-running counters (always run, cleared only by rst):
- trill_cnt counts 0..TRILL_MS-1; tone_sel toggles on wrap.
- half toggles every cycle.
- beep_cnt counts 0..BEEP_PERIOD_MS-1.

Piezo output (next-state mux, priority order):
- alarm_ringing:
  - tone_sel==0: toggle every cycle (500 Hz).
  - tone_sel==1: toggle on cycles where half==1 (250 Hz).
- else tm_alarm: toggle while beep_cnt < BEEP_ON_MS, otherwise 0.
- else chime state == ON: toggle every cycle.
- else 0.

Latency and boundaries:
- Trigger to state ON takes 1 edge; the first piezo toggle is on the following edge.
- When every source deasserts, piezo is 0 one edge later.
- A source switch mid-pattern continues from the current counter phase; there is no pattern restart.
- Reset mid-chime returns to IDLE with piezo=0 at that edge.

Optional Feature:
- Macro: PIEZO_QUIET_HOURS_EN.
- Defined: chime triggers are ignored when hour_kst >= 22 or hour_kst <= 6. A chime already running at 22:00 is not possible, since a trigger re-arms. Alarm and timer sounds are unaffected.
- Undefined: every hour chimes.

Decomposition:
- Shared package: the chime state enum (IDLE/ON/OFF) and the default timing constants, so the LCD and top can reference them.
- One natural sub-module, chime_fsm: trigger detection, target calculation and stroke FSM, exporting chime_on, chime_active and chime_strokes. The tone mux stays in piezo_sequencer.

Test Plan:
- Reset, then hold rst low with cur_sec=0 and cur_min=0 -> no chime. piezo stays 0 for 2000 cycles.
- Step cur_sec 59->0 with cur_min=0 and hour_kst=15 -> 3 strokes, each 200 toggling cycles plus 300 silent. chime_strokes ends at 3. chime_active stays high for 1500 cycles.
- hour_kst=0 chime -> 12 strokes (6000 cycles). hour_kst=12 -> 12 strokes.
- alarm_ringing=1 for 200 cycles:
  - piezo toggles every cycle for 50 cycles, then every 2nd cycle for 50, and this repeats.
  - Drop alarm_ringing -> piezo=0 on the next edge.
- tm_alarm=1 together with an active chime -> the timer beep pattern wins. The chime continues internally, and chime_strokes still reaches its target on time.
- With PIEZO_QUIET_HOURS_EN defined, trigger at hour_kst=23 and at hour_kst=6 -> chime_active never rises. Trigger at hour_kst=7 -> 7 strokes.
